wb_port_arbiter: RTL and testbench

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

---
 rtl/wb_port_arbiter.sv | 137 +++++++++++++
 tb/tb_wb_port_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_port_arbiter
// Description : Two-requester write-back arbiter with a 2-entry FIFO per port,
//               round-robin selection on contention and a registered
//               register-file write port. Optional macro WB_ARB_BYPASS_EN lets
//               an arbitration-winning request into an empty FIFO skip it.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_port_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [3:0]  req0_dest,
    input  logic [31:0] req0_data,
    input  logic        req1_valid,
    input  logic [3:0]  req1_dest,
    input  logic [31:0] req1_data,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic        writeBackEn,
    output logic [3:0]  Dest_wb,
    output logic [31:0] Result_WB,
    input  logic [3:0]  query_reg,
    output logic        query_pending
);

    localparam logic [1:0] c_CNT_FULL = 2'd2;

    // Entry layout: {dest[3:0], data[31:0]}
    logic [1:0][1:0][35:0] r_mem;
    logic [1:0][1:0]       r_cnt;
    logic [1:0]            r_wptr;
    logic [1:0]            r_rptr;
    logic                  r_rr;

    logic [1:0]            w_valid;
    logic [1:0][35:0]      w_entry;
    logic [1:0]            w_ready;
    logic [1:0]            w_push;
    logic [1:0]            w_head_vld;
    logic [1:0]            w_cand;
    logic [1:0]            w_grant;
    logic [1:0]            w_bypass;
    logic [1:0]            w_pop;
    logic [1:0]            w_fifo_wr;
    logic                  w_contend;
    logic                  w_sel;
    logic [35:0]           w_out_entry;
    logic                  w_buf_hit;

    assign w_valid    = {req1_valid, req0_valid};
    assign w_entry    = {{req1_dest, req1_data}, {req0_dest, req0_data}};
    assign req0_ready = w_ready[0];
    assign req1_ready = w_ready[1];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            w_ready[i]    = !rst && (r_cnt[i] != c_CNT_FULL);
            w_push[i]     = w_valid[i] && w_ready[i];
            w_head_vld[i] = (r_cnt[i] != 2'd0);
`ifdef WB_ARB_BYPASS_EN
            w_cand[i]     = w_head_vld[i] || w_push[i];
`else
            w_cand[i]     = w_head_vld[i];
`endif
        end
    end

    assign w_contend  = w_cand[0] && w_cand[1];
    assign w_grant[0] = w_cand[0] && (!w_cand[1] || !r_rr);
    assign w_grant[1] = w_cand[1] && (!w_cand[0] ||  r_rr);
    assign w_sel      = w_grant[1];

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            // A granted candidate with an empty FIFO can only be a bypass.
            w_bypass[i]  = w_grant[i] && !w_head_vld[i];
            w_pop[i]     = w_grant[i] &&  w_head_vld[i];
            w_fifo_wr[i] = w_push[i]  && !w_bypass[i];
        end
    end

    assign w_out_entry = w_bypass[w_sel] ? w_entry[w_sel] : r_mem[w_sel][r_rptr[w_sel]];

    always_comb begin
        w_buf_hit = 1'b0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 2; j++) begin
                if (((r_cnt[i] == c_CNT_FULL) || ((r_cnt[i] == 2'd1) && (r_rptr[i] == 1'(j))))
                    && (r_mem[i][j][35:32] == query_reg)) begin
                    w_buf_hit = 1'b1;
                end
            end
        end
    end

    assign query_pending = w_buf_hit || (writeBackEn && (Dest_wb == query_reg));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_rr        <= 1'b0;
            writeBackEn <= 1'b0;
            Dest_wb     <= 4'd0;
            Result_WB   <= 32'd0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (w_fifo_wr[i]) begin
                    r_mem[i][r_wptr[i]] <= w_entry[i];
                    r_wptr[i]           <= ~r_wptr[i];
                end
                if (w_pop[i]) begin
                    r_rptr[i] <= ~r_rptr[i];
                end
                case ({w_fifo_wr[i], w_pop[i]})
                    2'b10:   r_cnt[i] <= r_cnt[i] + 2'd1;
                    2'b01:   r_cnt[i] <= r_cnt[i] - 2'd1;
                    default: r_cnt[i] <= r_cnt[i];
                endcase
            end
            // On contention the pointer moves to whichever side lost.
            if (w_contend) begin
                r_rr <= w_grant[0];
            end
            writeBackEn <= |w_grant;
            if (|w_grant) begin
                Dest_wb   <= w_out_entry[35:32];
                Result_WB <= w_out_entry[31:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wb_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_port_arbiter
// Description : Directed vector bench for wb_port_arbiter (default build).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic [3:0]  req0_dest, req1_dest;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready;
    logic        writeBackEn;
    logic [3:0]  Dest_wb;
    logic [31:0] Result_WB;
    logic [3:0]  query_reg;
    logic        query_pending;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    wb_port_arbiter dut (
        .clk          (clk),
        .rst          (rst),
        .req0_valid   (req0_valid),
        .req0_dest    (req0_dest),
        .req0_data    (req0_data),
        .req1_valid   (req1_valid),
        .req1_dest    (req1_dest),
        .req1_data    (req1_data),
        .req0_ready   (req0_ready),
        .req1_ready   (req1_ready),
        .writeBackEn  (writeBackEn),
        .Dest_wb      (Dest_wb),
        .Result_WB    (Result_WB),
        .query_reg    (query_reg),
        .query_pending(query_pending)
    );

    // Inputs for one cycle, combinational expectations before the edge,
    // registered expectations after it.
    typedef struct {
        logic        rst;
        logic        v0;
        logic [3:0]  d0;
        logic [31:0] x0;
        logic        v1;
        logic [3:0]  d1;
        logic [31:0] x1;
        logic [3:0]  q;
        logic        r0;
        logic        r1;
        logic        qp;
        logic        en;
        logic [3:0]  dst;
        logic [31:0] dat;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input logic rs, input logic v0, input logic [3:0] d0, input logic [31:0] x0,
                       input logic v1, input logic [3:0] d1, input logic [31:0] x1, input logic [3:0] q,
                       input logic r0, input logic r1, input logic qp,
                       input logic en, input logic [3:0] dst, input logic [31:0] dat);
        vec_t v;
        v.rst = rs; v.v0 = v0; v.d0 = d0; v.x0 = x0; v.v1 = v1; v.d1 = d1; v.x1 = x1; v.q = q;
        v.r0 = r0; v.r1 = r1; v.qp = qp; v.en = en; v.dst = dst; v.dat = dat;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s step %0d: got %0h, expected %0h", name, idx, act, exp);
        else
            n_pass++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int edges;

        rst = 1'b1;
        req0_valid = 1'b0; req0_dest = '0; req0_data = '0;
        req1_valid = 1'b0; req1_dest = '0; req1_data = '0;
        query_reg  = '0;

        //   rst v0 d0 x0        v1 d1 x1       q   r0 r1 qp  en dst dat
        row(1, 0, 0, 0,       0, 0, 0,       0,  0, 0, 0,  0, 0,  0);
        row(1, 0, 0, 0,       0, 0, 0,       0,  0, 0, 0,  0, 0,  0);
        // single request, latency and query lifetime
        row(0, 1, 3, 'h1234,  0, 0, 0,       3,  1, 1, 0,  0, 0,  0);
        row(0, 0, 0, 0,       0, 0, 0,       3,  1, 1, 1,  1, 3,  'h1234);
        row(0, 0, 0, 0,       0, 0, 0,       3,  1, 1, 1,  0, 3,  'h1234);
        row(0, 0, 0, 0,       0, 0, 0,       3,  1, 1, 0,  0, 3,  'h1234);
        // contention: write order 1,5,2,6
        row(0, 1, 1, 'hA1,    1, 5, 'hB5,    1,  1, 1, 0,  0, 3,  'h1234);
        row(0, 1, 2, 'hA2,    1, 6, 'hB6,    5,  1, 1, 1,  1, 1,  'hA1);
        row(0, 0, 0, 0,       0, 0, 0,       6,  1, 0, 1,  1, 5,  'hB5);
        row(0, 0, 0, 0,       0, 0, 0,       1,  1, 1, 0,  1, 2,  'hA2);
        row(0, 0, 0, 0,       0, 0, 0,       2,  1, 1, 1,  1, 6,  'hB6);
        row(0, 0, 0, 0,       0, 0, 0,       6,  1, 1, 1,  0, 6,  'hB6);
        // streaming both ports: FIFOs fill, ready drops, nothing is lost
        row(0, 1, 8, 'hC0,    1, 11, 'hD0,   8,  1, 1, 0,  0, 6,  'hB6);
        row(0, 1, 9, 'hC1,    1, 12, 'hD1,   8,  1, 1, 1,  1, 11, 'hD0);
        row(0, 1, 10, 'hC2,   1, 13, 'hD2,   13, 0, 1, 0,  1, 8,  'hC0);
        row(0, 1, 10, 'hC2,   0, 0, 0,       13, 1, 0, 1,  1, 12, 'hD1);
        row(0, 0, 0, 0,       0, 0, 0,       10, 0, 1, 1,  1, 9,  'hC1);
        row(0, 0, 0, 0,       0, 0, 0,       9,  1, 1, 1,  1, 13, 'hD2);
        row(0, 0, 0, 0,       0, 0, 0,       13, 1, 1, 1,  1, 10, 'hC2);
        row(0, 0, 0, 0,       0, 0, 0,       10, 1, 1, 1,  0, 10, 'hC2);
        row(0, 0, 0, 0,       0, 0, 0,       10, 1, 1, 0,  0, 10, 'hC2);
        // push and pop on req1 in the same cycle
        row(0, 0, 0, 0,       1, 4, 'hE4,    4,  1, 1, 0,  0, 10, 'hC2);
        row(0, 0, 0, 0,       1, 7, 'hE7,    4,  1, 1, 1,  1, 4,  'hE4);
        row(0, 0, 0, 0,       0, 0, 0,       7,  1, 1, 1,  1, 7,  'hE7);
        row(0, 0, 0, 0,       0, 0, 0,       7,  1, 1, 1,  0, 7,  'hE7);
        // reset in the middle of traffic
        row(0, 1, 1, 'hF1,    1, 2, 'hF2,    8,  1, 1, 0,  0, 7,  'hE7);
        row(0, 1, 3, 'hF3,    1, 4, 'hF4,    2,  1, 1, 1,  1, 1,  'hF1);
        row(1, 1, 5, 'hF5,    1, 6, 'hF6,    9,  0, 0, 0,  0, 0,  0);
        row(0, 1, 5, 'hF5,    0, 0, 0,       4,  1, 1, 0,  0, 0,  0);
        row(0, 0, 0, 0,       0, 0, 0,       5,  1, 1, 1,  1, 5,  'hF5);
        row(0, 0, 0, 0,       0, 0, 0,       5,  1, 1, 1,  0, 5,  'hF5);

        repeat (2) @(posedge clk);

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            rst        = tbl[i].rst;
            req0_valid = tbl[i].v0; req0_dest = tbl[i].d0; req0_data = tbl[i].x0;
            req1_valid = tbl[i].v1; req1_dest = tbl[i].d1; req1_data = tbl[i].x1;
            query_reg  = tbl[i].q;
            #1;
            chk("req0_ready",    i, 32'(req0_ready),    32'(tbl[i].r0));
            chk("req1_ready",    i, 32'(req1_ready),    32'(tbl[i].r1));
            chk("query_pending", i, 32'(query_pending), 32'(tbl[i].qp));
            @(posedge clk);
            #1;
            chk("writeBackEn",   i, 32'(writeBackEn),   32'(tbl[i].en));
            chk("Dest_wb",       i, 32'(Dest_wb),       32'(tbl[i].dst));
            chk("Result_WB",     i, Result_WB,          tbl[i].dat);
        end

        // Accept-to-write latency on req1, bounded wait.
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_dest = 4'd9; req1_data = 32'h55;
        @(posedge clk);
        #1;
        edges = 1;
        req1_valid = 1'b0;
        while (!writeBackEn && edges < 10) begin
            @(posedge clk);
            #1;
            edges++;
        end
`ifdef WB_ARB_BYPASS_EN
        chk("latency", 100, 32'(edges), 32'd1);
`else
        chk("latency", 100, 32'(edges), 32'd2);
`endif
        chk("lat_dest", 101, 32'(Dest_wb), 32'd9);
        chk("lat_data", 102, Result_WB, 32'h55);
        @(posedge clk);
        #1;
        chk("lat_en_drop", 103, 32'(writeBackEn), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
